alu_pipe_mdu: RTL and testbench

//  Parametrised, handshaked successor to the single-cycle datapath ALU. Executes
//  the eight base ops in one registered cycle; with the optional feature, adds an

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_mdu_iter.sv | 90 +++++++++
 rtl/alu_pipe_mdu.sv | 112 +++++++++++
 tb/tb_alu_pipe_mdu.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op codes, FSM states and helpers for the pipelined ALU with optional
// iterative multiply/divide unit.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_OR   = 4'd3,
    OP_AND  = 4'd4,
    OP_SLTU = 4'd5,
    OP_SLT  = 4'd6,
    OP_XOR  = 4'd7,
    OP_MUL  = 4'd8,
    OP_MULH = 4'd9,
    OP_DIVU = 4'd10,
    OP_REMU = 4'd11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Codes 8..11 form the multiply/divide group: bit1 selects divide, bit0 the high half.
  function automatic logic is_mdu_op(input logic [ALU_OP_W-1:0] op);
    return (op[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative unsigned multiply/divide, one bit per cycle: shift-add multiplier and
// restoring divider sharing a 2*WIDTH accumulator and a single WIDTH+1 adder.
module alu_mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             i_start,
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);

  localparam int SHW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_div;
  logic               r_run;
  logic [SHW-1:0]     r_cnt;

  logic [WIDTH-1:0]   w_hi;
  logic [WIDTH-1:0]   w_lo;
  logic [WIDTH:0]     w_x;
  logic [WIDTH:0]     w_y;
  logic               w_cin;
  logic [WIDTH+1:0]   w_sum;
  logic [2*WIDTH-1:0] w_acc_nxt;

  assign w_hi = r_acc[2*WIDTH-1:WIDTH];
  assign w_lo = r_acc[WIDTH-1:0];

  // Multiply adds the multiplicand into the high half; divide subtracts the
  // divisor from the left-shifted partial remainder (carry out == no borrow).
  always_comb begin
    w_x   = {1'b0, w_hi};
    w_y   = {1'b0, r_opnd};
    w_cin = 1'b0;
    if (r_div) begin
      w_x   = {w_hi, w_lo[WIDTH-1]};
      w_y   = ~{1'b0, r_opnd};
      w_cin = 1'b1;
    end
  end

  assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{(WIDTH+1){1'b0}}, w_cin};

  always_comb begin
    w_acc_nxt = {1'b0, w_hi, w_lo[WIDTH-1:1]};
    if (r_div) begin
      if (w_sum[WIDTH+1])
        w_acc_nxt = {w_sum[WIDTH-1:0], w_lo[WIDTH-2:0], 1'b1};
      else
        w_acc_nxt = {r_acc[2*WIDTH-2:0], 1'b0};
    end else if (w_lo[0]) begin
      w_acc_nxt = {w_sum[WIDTH:0], w_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_acc  <= '0;
      r_opnd <= '0;
      r_div  <= 1'b0;
      r_run  <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_acc  <= {{WIDTH{1'b0}}, (i_div ? i_a : i_b)};
      r_opnd <= i_div ? i_b : i_a;
      r_div  <= i_div;
      r_run  <= 1'b1;
      r_cnt  <= '0;
    end else if (r_run) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + SHW'(1);
      if (o_done)
        r_run <= 1'b0;
    end
  end

  // The final step's result is presented combinationally so the parent can
  // capture it on the same edge that retires the operation.
  assign o_done = r_run && (r_cnt == SHW'(WIDTH-1));
  assign o_lo   = w_acc_nxt[WIDTH-1:0];
  assign o_hi   = w_acc_nxt[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_pipe_mdu.sv
// Handshaked registered ALU; define ALU_MULDIV_EN to add the iterative
// unsigned multiply/divide unit for ops 8..11.
module alu_pipe_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    result,
  output logic                zero,
  output logic                busy
);

  localparam int SHW = $clog2(WIDTH);

  state_e           r_state;
  logic [WIDTH-1:0] r_result;
  logic             w_accept;

  function automatic logic [WIDTH-1:0] base_alu(input logic [ALU_OP_W-1:0] f_op,
                                                input logic [WIDTH-1:0]    f_a,
                                                input logic [WIDTH-1:0]    f_b);
    case (f_op)
      OP_ADD:  return f_a + f_b;
      OP_SUB:  return f_a - f_b;
      OP_SLL:  return f_b << f_a[SHW-1:0];
      OP_OR:   return f_a | f_b;
      OP_AND:  return f_a & f_b;
      OP_SLTU: return {{(WIDTH-1){1'b0}}, (f_a < f_b)};
      OP_SLT:  return {{(WIDTH-1){1'b0}}, ($signed(f_a) < $signed(f_b))};
      OP_XOR:  return f_a ^ f_b;
      OP_MUL, OP_MULH, OP_DIVU, OP_REMU: return '0;
      default: return f_a + f_b;
    endcase
  endfunction

  // A finished result may be retired and replaced in the same cycle.
  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign zero      = (r_state == S_DONE) && (r_result == '0);

`ifdef ALU_MULDIV_EN
  logic             r_sel_hi;
  logic             w_start;
  logic             w_mdu_done;
  logic [WIDTH-1:0] w_mdu_lo;
  logic [WIDTH-1:0] w_mdu_hi;

  assign w_start = w_accept && is_mdu_op(op);
  assign busy    = (r_state == S_BUSY);

  alu_mdu_iter #(
    .WIDTH (WIDTH)
  ) u_mdu (
    .CLK     (CLK),
    .Reset   (Reset),
    .i_start (w_start),
    .i_div   (op[1]),
    .i_a     (a),
    .i_b     (b),
    .o_done  (w_mdu_done),
    .o_lo    (w_mdu_lo),
    .o_hi    (w_mdu_hi)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_sel_hi <= 1'b0;
    end else if (w_accept) begin
      if (is_mdu_op(op)) begin
        r_state  <= S_BUSY;
        r_sel_hi <= op[0];
      end else begin
        r_state  <= S_DONE;
        r_result <= base_alu(op, a, b);
      end
    end else if ((r_state == S_BUSY) && w_mdu_done) begin
      r_state  <= S_DONE;
      r_result <= r_sel_hi ? w_mdu_hi : w_mdu_lo;
    end else if ((r_state == S_DONE) && out_ready) begin
      r_state <= S_IDLE;
    end
  end
`else
  assign busy = 1'b0;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state  <= S_IDLE;
      r_result <= '0;
    end else if (w_accept) begin
      r_state  <= S_DONE;
      r_result <= base_alu(op, a, b);
    end else if ((r_state == S_DONE) && out_ready) begin
      r_state <= S_IDLE;
    end
  end
`endif

endmodule

// File: tb/tb_alu_pipe_mdu.sv
// Self-checking bench for alu_pipe_mdu: directed vector table, random ops against
// a behavioural model, back-pressure and mid-operation reset sequences.
module tb_alu_pipe_mdu;

`ifdef ALU_MULDIV_EN
  localparam bit MDU = 1'b1;
`else
  localparam bit MDU = 1'b0;
`endif

  logic        CLK;
  logic        Reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_pipe_mdu #(.WIDTH(32)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] f_op, input logic [31:0] f_a,
                                          input logic [31:0] f_b);
    logic [63:0] prod;
    prod = {32'd0, f_a} * {32'd0, f_b};
    case (f_op)
      4'd0:  return f_a + f_b;
      4'd1:  return f_a - f_b;
      4'd2:  return f_b << f_a[4:0];
      4'd3:  return f_a | f_b;
      4'd4:  return f_a & f_b;
      4'd5:  return (f_a < f_b) ? 32'd1 : 32'd0;
      4'd6:  return ($signed(f_a) < $signed(f_b)) ? 32'd1 : 32'd0;
      4'd7:  return f_a ^ f_b;
      4'd8:  return MDU ? prod[31:0] : 32'd0;
      4'd9:  return MDU ? prod[63:32] : 32'd0;
      4'd10: return !MDU ? 32'd0 : ((f_b == 0) ? 32'hFFFF_FFFF : f_a / f_b);
      4'd11: return !MDU ? 32'd0 : ((f_b == 0) ? f_a : f_a % f_b);
      default: return f_a + f_b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] f_op);
    return (MDU && (f_op >= 4'd8) && (f_op <= 4'd11)) ? 33 : 1;
  endfunction

  // Called at #1 after a rising edge; returns at #1 after the edge where out_valid rose.
  task automatic run_op(input logic [3:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                        output logic [31:0] t_res, output logic t_z, output int t_lat);
    int wait_cnt;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 200) begin
      @(posedge CLK); #1;
      wait_cnt++;
    end
    if (wait_cnt >= 200) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    op = t_op;
    a  = t_a;
    b  = t_b;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    t_lat = 1;
    while (!out_valid && t_lat < 200) begin
      @(posedge CLK); #1;
      t_lat++;
    end
    t_res = result;
    t_z   = zero;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] res;
    logic        z;
    int          lat;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;

    vecs[0]  = '{"add_wrap", 4'd0,  32'hFFFF_FFFF, 32'd1,       32'd0,       1};
    vecs[1]  = '{"slt_neg",  4'd6,  32'h8000_0000, 32'd1,       32'd1,       1};
    vecs[2]  = '{"sltu_big", 4'd5,  32'h8000_0000, 32'd1,       32'd0,       1};
    vecs[3]  = '{"sll",      4'd2,  32'h24,        32'd1,       32'h10,      1};
    vecs[4]  = '{"sub_wrap", 4'd1,  32'd3,         32'd5,       32'hFFFF_FFFE, 1};
    vecs[5]  = '{"or",       4'd3,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1};
    vecs[6]  = '{"and",      4'd4,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1};
    vecs[7]  = '{"xor",      4'd7,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1};
    vecs[8]  = '{"rsv_add",  4'd13, 32'd40,        32'd2,       32'd42,      1};
`ifdef ALU_MULDIV_EN
    vecs[9]  = '{"mul",      4'd8,  32'h1_0000,    32'h1_0000,  32'd0,       33};
    vecs[10] = '{"mulh",     4'd9,  32'h1_0000,    32'h1_0000,  32'd1,       33};
    vecs[11] = '{"divu",     4'd10, 32'd100,       32'd7,       32'd14,      33};
    vecs[12] = '{"remu",     4'd11, 32'd100,       32'd7,       32'd2,       33};
    vecs[13] = '{"divu_z",   4'd10, 32'd100,       32'd0,       32'hFFFF_FFFF, 33};
    vecs[14] = '{"remu_z",   4'd11, 32'd100,       32'd0,       32'd100,     33};
    vecs[15] = '{"mul_max",  4'd8,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,     33};
`else
    vecs[9]  = '{"mul",      4'd8,  32'h1_0000,    32'h1_0000,  32'd0,       1};
    vecs[10] = '{"mulh",     4'd9,  32'h1_0000,    32'h1_0000,  32'd0,       1};
    vecs[11] = '{"divu",     4'd10, 32'd100,       32'd7,       32'd0,       1};
    vecs[12] = '{"remu",     4'd11, 32'd100,       32'd7,       32'd0,       1};
    vecs[13] = '{"divu_z",   4'd10, 32'd100,       32'd0,       32'd0,       1};
    vecs[14] = '{"remu_z",   4'd11, 32'd100,       32'd0,       32'd0,       1};
    vecs[15] = '{"mul_max",  4'd8,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,     1};
`endif

    Reset     = 1'b0;
    in_valid  = 1'b0;
    op        = 4'd0;
    a         = 32'd0;
    b         = 32'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result",    result,             32'd0);
    chk("rst_zero",      {31'd0, zero},      32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    Reset = 1'b1;
    @(posedge CLK); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, z, lat);
      chk({vecs[i].name, "_res"}, res, vecs[i].exp);
      chk({vecs[i].name, "_zero"}, {31'd0, z}, {31'd0, (vecs[i].exp == 32'd0)});
      chk({vecs[i].name, "_lat"}, lat, vecs[i].lat);
    end

    for (int n = 0; n < 40; n++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a  = $urandom;
      r_b  = (n % 4 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if (n % 5 == 1) r_a = 32'($urandom_range(0, 63));
      run_op(r_op, r_a, r_b, res, z, lat);
      chk($sformatf("rnd%0d_op%0d_res", n, r_op), res, ref_alu(r_op, r_a, r_b));
      chk($sformatf("rnd%0d_zero", n), {31'd0, z}, {31'd0, (ref_alu(r_op, r_a, r_b) == 32'd0)});
      chk($sformatf("rnd%0d_lat", n), lat, ref_lat(r_op));
    end

    // Back-pressure: result must hold while the consumer stalls.
    @(posedge CLK); #1;
    out_ready = 1'b0;
    run_op(4'd0, 32'd3, 32'd4, res, z, lat);
    chk("bp_first", res, 32'd7);
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK); #1;
      chk($sformatf("bp_hold%0d_res", k), result, 32'd7);
      chk($sformatf("bp_hold%0d_vld", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp_hold%0d_rdy", k), {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op        = 4'd7;
    a         = 32'd5;
    b         = 32'd3;
    #1;
    chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    chk("b2b_vld", {31'd0, out_valid}, 32'd1);
    chk("b2b_res", result, 32'd6);

    // Reset in the middle of a divide.
    @(posedge CLK); #1;
    in_valid = 1'b1;
    op       = 4'd10;
    a        = 32'd100;
    b        = 32'd7;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge CLK); #1;
    end
`ifdef ALU_MULDIV_EN
    chk("midrst_busy_before", {31'd0, busy}, 32'd1);
`endif
    Reset = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_busy",      {31'd0, busy},      32'd0);
    chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("midrst_result",    result,             32'd0);
    @(posedge CLK); #1;
    Reset = 1'b1;
    @(posedge CLK); #1;
    run_op(4'd0, 32'd5, 32'd6, res, z, lat);
    chk("postrst_res", res, 32'd11);
    chk("postrst_lat", lat, 1);
    run_op(4'd11, 32'd100, 32'd7, res, z, lat);
    chk("postrst_remu", res, ref_alu(4'd11, 32'd100, 32'd7));
    chk("postrst_remu_lat", lat, ref_lat(4'd11));

    @(posedge CLK); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
